// File: rtl/hist_pkg.sv
// rtl/hist_pkg.sv - shared types and constants for the histogram bank controller
package hist_pkg;

  localparam int NUM_TILES = 16;
  localparam int NUM_BINS  = 256;
  localparam int TILE_W    = 4;
  localparam int BIN_W     = 8;
  localparam int HIST_W    = 16;

  // Lifecycle of one histogram bank
  typedef enum logic [1:0] {
    B_CLEAN = 2'd0,
    B_FILL  = 2'd1,
    B_PROC  = 2'd2,
    B_DIRTY = 2'd3
  } bank_state_e;

  // Top-level sequencing states
  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/hist_clear_seq.sv
// rtl/hist_clear_seq.sv - zero-fill sweep over every tile and bin of one bank
module hist_clear_seq
  import hist_pkg::*;
#(
  parameter int NUM_TILES = hist_pkg::NUM_TILES,
  parameter int NUM_BINS  = hist_pkg::NUM_BINS,
  localparam int TW = $clog2(NUM_TILES),
  localparam int BW = $clog2(NUM_BINS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          bank,
  output logic          clr_we,
  output logic [TW:0]   clr_block,
  output logic [BW-1:0] clr_addr,
  output logic          done,
  output logic          busy,
  output logic          cur_bank
);

  localparam int CW = TW + BW;
  localparam logic [CW-1:0] LAST = CW'(NUM_TILES * NUM_BINS - 1);

  logic          busy_q;
  logic          bank_q;
  logic [CW-1:0] cnt_q;

  // done marks the cycle carrying the final write, so a queued bank can start right behind it
  assign done      = busy_q && (cnt_q == LAST);
  assign busy      = busy_q;
  assign cur_bank  = bank_q;
  assign clr_we    = busy_q;
  assign clr_block = busy_q ? {bank_q, cnt_q[CW-1:BW]} : '0;
  assign clr_addr  = busy_q ? cnt_q[BW-1:0] : '0;

  // Sweep counter: tile is the upper field, bin the lower, one write per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      bank_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start && (!busy_q || done)) begin
      busy_q <= 1'b1;
      bank_q <= bank;
      cnt_q  <= '0;
    end else if (busy_q) begin
      busy_q <= !done;
      cnt_q  <= done ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/hist_bank_ctrl.sv
// rtl/hist_bank_ctrl.sv - ping-pong histogram bank sequencer; HIST_BANK_CTRL_STATS_EN adds frame/stall counters
module hist_bank_ctrl
  import hist_pkg::*;
#(
  parameter int NUM_TILES = hist_pkg::NUM_TILES,
  parameter int NUM_BINS  = hist_pkg::NUM_BINS,
  localparam int TW = $clog2(NUM_TILES),
  localparam int BW = $clog2(NUM_BINS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_done,
  input  logic          cdf_done,
  output logic          hist_en,
  output logic          area_flag,
  output logic          cdf_start,
  output logic          cdf_bank,
  output logic          clr_we,
  output logic [TW:0]   clr_block,
  output logic [BW-1:0] clr_addr,
  output logic          stall,
  output logic          err_spurious
`ifdef HIST_BANK_CTRL_STATS_EN
  ,
  output logic [15:0]   frame_cnt,
  output logic [31:0]   stall_cycles
`endif
);

  fsm_state_e  state_q;
  bank_state_e bank_q [2];
  bank_state_e bank_d [2];
  logic        hist_en_q, area_q, cdf_start_q, cdf_bank_q, stall_q, err_q;

  logic        seq_done, seq_busy, seq_bank;
  logic        clr_start, clr_start_bank;
  logic [1:0]  pend;
  logic        cdf_err, oth_clean, init_go, frame_run, wait_go;

  assign hist_en      = hist_en_q;
  assign area_flag    = area_q;
  assign cdf_start    = cdf_start_q;
  assign cdf_bank     = cdf_bank_q;
  assign stall        = stall_q;
  assign err_spurious = err_q;

  // Next bank states: clear completion first, then CDF release, then the FSM's fill/proc moves
  always_comb begin
    bank_d  = bank_q;
    cdf_err = 1'b0;
    if (seq_done) bank_d[seq_bank] = B_CLEAN;
    if (cdf_done) begin
      // the older PROC bank is the one the CDF stage is finishing
      if (bank_q[~cdf_bank_q] == B_PROC)     bank_d[~cdf_bank_q] = B_DIRTY;
      else if (bank_q[cdf_bank_q] == B_PROC) bank_d[cdf_bank_q]  = B_DIRTY;
      else                                   cdf_err = 1'b1;
    end
    oth_clean = (bank_d[~area_q] == B_CLEAN);
    init_go   = (state_q == S_INIT) && (bank_d[0] == B_CLEAN);
    frame_run = (state_q == S_RUN) && frame_done;
    wait_go   = (state_q == S_WAIT) && oth_clean;
    if (init_go) bank_d[0] = B_FILL;
    if (frame_run) begin
      bank_d[area_q] = B_PROC;
      if (oth_clean) bank_d[~area_q] = B_FILL;
    end
    if (wait_go) bank_d[~area_q] = B_FILL;
  end

  // A DIRTY bank requests a sweep unless it is the one mid-sweep; bank 0 wins ties
  assign pend[0]        = (bank_d[0] == B_DIRTY) && !(seq_busy && !seq_done && !seq_bank);
  assign pend[1]        = (bank_d[1] == B_DIRTY) && !(seq_busy && !seq_done && seq_bank);
  assign clr_start      = |pend;
  assign clr_start_bank = !pend[0];

  hist_clear_seq #(
    .NUM_TILES (NUM_TILES),
    .NUM_BINS  (NUM_BINS)
  ) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .start     (clr_start),
    .bank      (clr_start_bank),
    .clr_we    (clr_we),
    .clr_block (clr_block),
    .clr_addr  (clr_addr),
    .done      (seq_done),
    .busy      (seq_busy),
    .cur_bank  (seq_bank)
  );

  // Top FSM with registered handshake outputs and the bank-state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      bank_q[0]   <= B_DIRTY;
      bank_q[1]   <= B_DIRTY;
      hist_en_q   <= 1'b0;
      area_q      <= 1'b0;
      cdf_start_q <= 1'b0;
      cdf_bank_q  <= 1'b0;
      stall_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      cdf_start_q <= 1'b0;
      if (cdf_err || (frame_done && !hist_en_q)) err_q <= 1'b1;
      case (state_q)
        S_INIT: if (init_go) begin
          state_q   <= S_RUN;
          area_q    <= 1'b0;
          hist_en_q <= 1'b1;
        end
        S_RUN: if (frame_done) begin
          cdf_start_q <= 1'b1;
          cdf_bank_q  <= area_q;
          if (oth_clean) begin
            area_q <= ~area_q;
          end else begin
            hist_en_q <= 1'b0;
            stall_q   <= 1'b1;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: if (oth_clean) begin
          area_q    <= ~area_q;
          hist_en_q <= 1'b1;
          stall_q   <= 1'b0;
          state_q   <= S_RUN;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

`ifdef HIST_BANK_CTRL_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [31:0] stall_cyc_q;

  assign frame_cnt    = frame_cnt_q;
  assign stall_cycles = stall_cyc_q;

  // Accepted frames wrap; stall cycles saturate
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      stall_cyc_q <= '0;
    end else begin
      if (frame_run) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (stall_q && (stall_cyc_q != '1)) stall_cyc_q <= stall_cyc_q + 32'd1;
    end
  end
`else
`endif

endmodule
